conv2d_stream_engine: RTL
=========================

// Module: conv2d_stream_engine
// PURPOSE
//  Parametrised streaming 2-D convolution engine; successor to the fixed 4x4-input / 3x3-filter systolic array.
//  Accepts an IMG_W x IMG_H frame as a row-major pixel stream (valid/ready). Holds K x K signed weights.
//  Emits each valid (IMG_W-K+1) x (IMG_H-K+1) window sum as a stream, with optional ReLU and saturation.
//  Built from K-1 line buffers, a K x K window register and a MAC tree. Sits between the pixel source and the pooling/output stage.
// PARAMETERS
//  DW     8   pixel width (unsigned) and weight width (signed two's complement)
//  IMG_W  4   frame width in pixels, >= K
//  IMG_H  4   frame height in pixels, >= K
//  K      3   kernel edge; kernel holds K*K weights
//  ACC_W  24  internal signed accumulator width; must hold K*K*(2^DW-1)*2^(DW-1) without overflow
//  OUT_W  16  signed output width
//  SAT    1   1: clamp to OUT_W signed range; 0: keep low OUT_W bits (wrap)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  w_load    in   1      weight write strobe
//  w_data    in   DW     signed weight, written row-major
//  relu_en   in   1      1: negative sums become 0 before saturation/wrap
//  in_valid  in   1      pixel valid
//  in_ready  out  1      engine can accept a pixel
//  in_data   in   DW     unsigned pixel, row-major
//  out_valid out  1      out_data valid
//  out_ready in   1      consumer accepts out_data
//  out_data  out  OUT_W  signed convolution result
//  out_last  out  1      qualifies the final output of a frame
//  busy      out  1      frame in progress (state != IDLE)
// BEHAVIOUR
//  Reset: the following take effect on the next clk edge.
//   Outputs: out_valid=0, out_data=0, out_last=0, busy=0, in_ready=0 while rst is high.
//   State: IDLE; row/col/weight counters=0; all weights=0; line buffers and window are don't-care.
//   rst mid-frame abandons the frame; any pending output is dropped.
//  Weights: w_load is honoured only in IDLE. Each strobe writes w_data to w[widx] and advances widx.
//   widx wraps K*K-1 -> 0. w_load during RUN/FLUSH is ignored and widx is unchanged.
//  in_ready = !rst && state!=FLUSH && (!out_valid || out_ready). Pixel accepted when in_valid && in_ready.
//  FSM:
//   IDLE -> RUN on the first accepted pixel.
//   RUN -> FLUSH when the pixel at (row=IMG_H-1, col=IMG_W-1) is accepted.
//   FLUSH -> IDLE when the last output handshakes (out_valid && out_ready && out_last).
//  Counters: col advances on each accepted pixel; col wraps IMG_W-1 -> 0 and increments row.
//   Both return to 0 after the last pixel.
//  Window is complete when the accepted pixel has row >= K-1 and col >= K-1. The window never spans a row boundary.
//  Latency: out_valid rises on the clk edge that accepts the window-completing pixel (1 cycle).
//   out_data is computed from the window including that pixel.
//  Output register: single entry. Holds out_data/out_last stable while out_valid && !out_ready.
//   In-stream stall is via in_ready. Accept and drain in the same cycle is allowed (full throughput).
//  Arithmetic: sum = SUM w[i][j] * pix[r-K+1+i][c-K+1+j] in ACC_W signed; pixels are zero-extended.
//   If relu_en && sum<0, sum=0.
//   SAT=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. SAT=0: take sum[OUT_W-1:0].
//  relu_en is sampled at the result-register load; changing it mid-frame affects later outputs only.
//  out_last=1 only with the output for window (IMG_H-K, IMG_W-K).
//  Frame yields exactly (IMG_W-K+1)*(IMG_H-K+1) outputs, row-major.
// TESTING
//  T1 defaults; 9 loads of w=1; pixels 1..16, out_ready=1 -> outputs 54,63,90,99; out_last only on 99; busy back to 0.
//  T2 as T1, out_ready low 5 cycles at first out_valid -> out_data holds 54, in_ready=0; then 54,63,90,99 unchanged.
//  T3 w center=-1, rest 0; relu_en=0 -> -6,-7,-10,-11; relu_en=1 -> 0,0,0,0.
//  T4 OUT_W=8, all pixels 255, w=1 -> SAT=1: 127 x4; SAT=0: -9 (0xF7) x4.
//  T5 rst after 10 pixels, then full 1..16 frame -> weights are 0, so outputs 0,0,0,0; no residual output before the frame.
//  T6 IMG_W=6, IMG_H=5, K=3, pixels = index, w=1, random in_valid/out_ready -> 12 outputs = 9*idx+63 (idx = top-left index); out_last on 12th; w_load during RUN ignored.

Source files
------------

// File: rtl/conv2d_stream_engine.sv
// Streaming K x K 2-D convolution over a row-major IMG_W x IMG_H pixel stream.
// K-1 line buffers feed a K x K window; each complete window is reduced by a MAC tree.
module conv2d_stream_engine #(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 4,
    parameter int unsigned IMG_H = 4,
    parameter int unsigned K     = 3,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned OUT_W = 16,
    parameter bit          SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_load,
    input  logic [DW-1:0]    w_data,
    input  logic             relu_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned NW = K * K;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN   = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN   = RW'(K - 1);
    localparam logic [IW-1:0] WIDX_LAST = IW'(NW - 1);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_t;

    state_t                  state;
    logic [RW-1:0]           row;
    logic [CW-1:0]           col;
    logic [IW-1:0]           widx;
    logic [DW-1:0]           w    [NW];
    logic [DW-1:0]           lb   [K-1][IMG_W];
    logic [DW-1:0]           win  [K][K];
    logic [DW-1:0]           nwin [K][K];
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] sum_r;
    logic [OUT_W-1:0]        res;
    logic                    accept;
    logic                    win_done;
    logic                    frame_end;

    assign in_ready  = !rst && (state != StFlush) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign win_done  = (row >= ROW_WIN) && (col >= COL_WIN);
    assign frame_end = (row == ROW_LAST) && (col == COL_LAST);
    assign busy      = (state != StIdle);

    // Window as it will be after this pixel shifts in; the result uses it the same cycle.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                nwin[i][j] = win[i][j+1];
            end
        end
        for (int i = 0; i < K - 1; i++) begin
            nwin[i][K-1] = lb[i][col];
        end
        nwin[K-1][K-1] = in_data;

        sum = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                sum = sum + ({{(ACC_W-DW){w[i*K+j][DW-1]}}, w[i*K+j]} *
                             {{(ACC_W-DW){1'b0}}, nwin[i][j]});
            end
        end

        sum_r = (relu_en && sum[ACC_W-1]) ? '0 : sum;

        res = sum_r[OUT_W-1:0];
        if (SAT) begin
            if (sum_r > MAX_V) begin
                res = MAX_V[OUT_W-1:0];
            end else if (sum_r < MIN_V) begin
                res = MIN_V[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            row       <= '0;
            col       <= '0;
            widx      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                w[i] <= '0;
            end
        end else begin
            if (state == StIdle && w_load) begin
                w[widx] <= w_data;
                widx    <= (widx == WIDX_LAST) ? '0 : widx + 1'b1;
            end

            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= frame_end ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (accept && win_done) begin
                out_valid <= 1'b1;
                out_data  <= res;
                out_last  <= frame_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                StIdle:  if (accept) state <= frame_end ? StFlush : StRun;
                StRun:   if (accept && frame_end) state <= StFlush;
                StFlush: if (out_valid && out_ready && out_last) state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Pixel storage carries no reset: its contents are never observed before being rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < K - 2; i++) begin
                lb[i][col] <= lb[i+1][col];
            end
            lb[K-2][col] <= in_data;
            win <= nwin;
        end
    end

endmodule
